// File: rtl/fir_pkg.sv
// Shared constants and elaboration-time helpers for the programmable FIR.
// Contents:
//   DEF_COEF_9    reset coefficient set for the 9-tap configuration (tap 0 in the low bits)
//   add_lvls()    number of registered adder-tree levels for a tap count
//   acc_w()       accumulator width, with growth for the adder tree
//   default_coef() reset value of one coefficient
package fir_pkg;

    localparam logic [9*16-1:0] DEF_COEF_9 = {
        16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F,
        16'h1496, 16'h1089, 16'h0AE4, 16'h04F6
    };

    function automatic int add_lvls(input int taps);
        return $clog2(taps);
    endfunction

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Non-9-tap builds reset to a unity-gain pass-through (impulse at tap 0).
    function automatic int default_coef(input int taps, input int i, input int frac_bits);
        if (taps == 9) begin
            return int'($signed(DEF_COEF_9[i*16 +: 16]));
        end
        return (i == 0) ? (1 << frac_bits) : 0;
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Registered binary adder tree with a travelling valid bit.
// Ports:
//   clk, rst_n      clock, asynchronous active-high reset
//   en              advance all levels
//   flush           clear all level valids (data is left as is)
//   in_valid        valid for in_data
//   in_data         N signed operands of IN_W bits, operand j at [j*IN_W +: IN_W]
//   sum             signed sum, IN_W+LVLS bits, LVLS cycles after the operands
//   out_valid       valid for sum
module fir_adder_tree #(
    parameter int N    = 9,
    parameter int IN_W = 32,
    parameter int LVLS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [N*IN_W-1:0]      in_data,
    output logic [IN_W+LVLS-1:0]   sum,
    output logic                   out_valid
);

    localparam int SUM_W = IN_W + LVLS;

    // Each level holds 2*N slots; slots past the live element count stay zero, so
    // every level is a plain pairwise add and an odd element pairs with a zero.
    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        logic signed [SUM_W-1:0] node [2*N];
        logic                    vld;

        if (l == 0) begin : g_leaf
            always_comb begin
                for (int j = 0; j < 2*N; j++) begin
                    node[j] = '0;
                end
                for (int j = 0; j < N; j++) begin
                    node[j] = SUM_W'($signed(in_data[j*IN_W +: IN_W]));
                end
            end
            assign vld = in_valid;
        end else begin : g_add
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    for (int j = 0; j < 2*N; j++) begin
                        node[j] <= '0;
                    end
                    vld <= 1'b0;
                end else begin
                    if (flush) begin
                        vld <= 1'b0;
                    end else if (en) begin
                        vld <= g_lvl[l-1].vld;
                    end
                    if (en) begin
                        for (int j = 0; j < N; j++) begin
                            node[j] <= g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
                        end
                    end
                end
            end
        end
    end

    assign sum       = g_lvl[LVLS].node[0];
    assign out_valid = g_lvl[LVLS].vld;

endmodule

// File: rtl/fir_stream_prog.sv
// Pipelined direct-form FIR with valid/ready streaming and double-buffered coefficients.
// Pipeline: delay line -> multiply -> adder tree ($clog2(TAPS) levels) -> round/saturate.
// Ports:
//   clk, rst_n            clock, asynchronous active-high reset
//   flush                 synchronous clear of delay line and in-flight samples
//   s_valid/s_ready/s_data   input sample stream
//   m_valid/m_ready/m_data   output sample stream; m_sat flags a clamped sample
//   coef_we/coef_addr/coef_wdata   shadow-bank write port
//   coef_swap             copy shadow bank into the active bank
module fir_stream_prog
    import fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 9,
    parameter int FRAC_BITS = 14,
    parameter int OUT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUT_W-1:0]         m_data,
    output logic                     m_sat,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    input  logic                     coef_swap
);

    localparam int LVLS   = add_lvls(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);

    // One extra bit so adding the rounding constant can never wrap.
    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(64'd1 << (FRAC_BITS - 1));
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

    logic en;
    logic take;

    assign en      = !m_valid || m_ready;
    assign s_ready = en && !flush;
    assign take    = s_valid && s_ready;

    // Delay line
    logic signed [DATA_W-1:0] delay [TAPS];
    logic                     delay_vld;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                delay[i] <= '0;
            end
            delay_vld <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < TAPS; i++) begin
                delay[i] <= '0;
            end
            delay_vld <= 1'b0;
        end else begin
            if (en) begin
                delay_vld <= take;
            end
            if (take) begin
                delay[0] <= $signed(s_data);
                for (int i = 1; i < TAPS; i++) begin
                    delay[i] <= delay[i-1];
                end
            end
        end
    end

    // Coefficient banks; the swap reads the shadow value from before a same-edge write.
    logic signed [COEF_W-1:0] shadow [TAPS];
    logic signed [COEF_W-1:0] active [TAPS];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                shadow[i] <= COEF_W'(default_coef(TAPS, i, FRAC_BITS));
                active[i] <= COEF_W'(default_coef(TAPS, i, FRAC_BITS));
            end
        end else begin
            if (coef_swap) begin
                for (int i = 0; i < TAPS; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (coef_we && (int'(coef_addr) < TAPS)) begin
                shadow[coef_addr] <= $signed(coef_wdata);
            end
        end
    end

    // Multiply stage
    logic signed [PROD_W-1:0] prod [TAPS];
    logic                     prod_vld;
    logic [TAPS*PROD_W-1:0]   prod_flat;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                prod[i] <= '0;
            end
            prod_vld <= 1'b0;
        end else begin
            if (flush) begin
                prod_vld <= 1'b0;
            end else if (en) begin
                prod_vld <= delay_vld;
            end
            if (en) begin
                for (int i = 0; i < TAPS; i++) begin
                    prod[i] <= delay[i] * active[i];
                end
            end
        end
    end

    always_comb begin
        prod_flat = '0;
        for (int i = 0; i < TAPS; i++) begin
            prod_flat[i*PROD_W +: PROD_W] = prod[i];
        end
    end

    // Adder tree
    logic [ACC_W-1:0] acc;
    logic             acc_vld;

    fir_adder_tree #(
        .N    (TAPS),
        .IN_W (PROD_W),
        .LVLS (LVLS)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .in_valid  (prod_vld),
        .in_data   (prod_flat),
        .sum       (acc),
        .out_valid (acc_vld)
    );

    // Round half up, then clamp to the output range.
    logic signed [ACC_W:0]  rnd;
    logic [OUT_W-1:0]       out_next;
    logic                   sat_next;

    always_comb begin
        rnd = ($signed({acc[ACC_W-1], acc}) + HALF) >>> FRAC_BITS;
        sat_next = 1'b0;
        out_next = rnd[OUT_W-1:0];
        if (rnd > OUT_MAX) begin
            sat_next = 1'b1;
            out_next = OUT_MAX[OUT_W-1:0];
        end else if (rnd < OUT_MIN) begin
            sat_next = 1'b1;
            out_next = OUT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sat   <= 1'b0;
        end else begin
            if (flush) begin
                m_valid <= 1'b0;
            end else if (en) begin
                m_valid <= acc_vld;
            end
            if (en) begin
                m_data <= out_next;
                m_sat  <= sat_next;
            end
        end
    end

endmodule
